seg7_scan: RTL

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/clock_pkg.sv | 29 ++
 rtl/bcd_to_seg7.sv | 15 +
 rtl/seg7_scan.sv | 98 +++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
package clock_pkg;

   localparam int N_DIGITS = 4;

   // Segments are active-low, ordered {g,f,e,d,c,b,a}; all-ones is a dark digit
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Decode table for codes 0..9, entry [i] is the pattern for digit i
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   // Frame-stable copy of the digit codes and blink selects
   typedef struct packed {
      logic [N_DIGITS-1:0][3:0] bcd;
      logic [N_DIGITS-1:0]      mask;
   } shadow_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes go dark.
module bcd_to_seg7
   import clock_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup for 0..9, blank for 10..15
   always_comb begin
      seg = SEG_BLANK;
      if (bcd < 4'd10) seg = SEG_TABLE[bcd];
   end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed display scanner with per-slot dead time,
// frame-aligned input capture and per-digit blinking.
module seg7_scan
   import clock_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd0,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd2,
   input  logic [3:0] bcd3,
   input  logic       blink,
   input  logic [3:0] blink_mask,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int DW = $clog2(N_DIGITS);

   // pre/dig describe the slot position the NEXT clock edge will display,
   // so the first edge after reset naturally lands on digit 0's dead time.
   logic [PW-1:0] pre;
   logic [DW-1:0] dig;
   logic [FW-1:0] fcnt;
   logic          phase;
   shadow_t       sh;
   logic [6:0]    dec_seg;
   logic          slot_start, slot_end, frame_end, blank;

   assign slot_start = (pre == '0);
   assign slot_end   = (pre == PW'(SCAN_DIV - 1));
   assign frame_end  = slot_end && (dig == DW'(N_DIGITS - 1));
   // blink is live; only the mask is frame-stable
   assign blank      = blink && sh.mask[dig] && phase;

   // Prescaler and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
         dig <= '0;
      end else if (slot_end) begin
         pre <= '0;
         dig <= dig + 1'b1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Frame counter and blink phase, free-running regardless of blink
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt  <= '0;
         phase <= 1'b0;
      end else if (frame_end) begin
         if (fcnt == FW'(BLINK_FRAMES - 1)) begin
            fcnt  <= '0;
            phase <= ~phase;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   // Capture inputs at the start of each frame so a frame never mixes values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh <= '0;
      end else if (slot_start && dig == '0) begin
         sh.bcd  <= {bcd3, bcd2, bcd1, bcd0};
         sh.mask <= blink_mask;
      end
   end

   bcd_to_seg7 u_dec (
      .bcd (sh.bcd[dig]),
      .seg (dec_seg)
   );

   // Registered drive: dark for one clock at each slot start to avoid ghosting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
      end else if (slot_start) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
      end else begin
         an  <= ~(4'b0001 << dig);
         seg <= blank ? SEG_BLANK : dec_seg;
      end
   end

endmodule
